// File: rtl/spawnout_queue_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : spawnout_queue_arbiter_if
// Description : Bundle between the spawn writers / spawnout queue memory and
//               the spawnout queue arbiter. The arbiter connects through the
//               slave modport; writers and memory use the master modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface spawnout_queue_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 64
);
  localparam int BE_BITS = DATA_BITS / 8;

  // requester side
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ-1:0]           done;
  logic [NUM_REQ-1:0]           gnt;
  logic [NUM_REQ*ADDR_BITS-1:0] req_addr;
  logic [NUM_REQ-1:0]           req_en;
  logic [NUM_REQ*BE_BITS-1:0]   req_we;
  logic [NUM_REQ*DATA_BITS-1:0] req_din;
  logic [NUM_REQ*DATA_BITS-1:0] req_dout;

  // shared memory port
  logic [ADDR_BITS-1:0]         spawnout_queue_addr;
  logic                         spawnout_queue_en;
  logic [BE_BITS-1:0]           spawnout_queue_we;
  logic [DATA_BITS-1:0]         spawnout_queue_din;
  logic [DATA_BITS-1:0]         spawnout_queue_dout;

  // status
  logic [2:0]                   owner;
  logic                         busy;
  logic                         wdt_err;

  modport slave (
    input  req, done, req_addr, req_en, req_we, req_din, spawnout_queue_dout,
    output gnt, req_dout, spawnout_queue_addr, spawnout_queue_en,
           spawnout_queue_we, spawnout_queue_din, owner, busy, wdt_err
  );

  modport master (
    output req, done, req_addr, req_en, req_we, req_din, spawnout_queue_dout,
    input  gnt, req_dout, spawnout_queue_addr, spawnout_queue_en,
           spawnout_queue_we, spawnout_queue_din, owner, busy, wdt_err
  );
endinterface
`default_nettype wire

// File: rtl/spawnout_queue_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spawnout_queue_arbiter
// Description : Round-robin arbiter sharing the single spawnout queue BRAM
//               port among NUM_REQ task-spawn writers. A grant is held for a
//               whole task-entry burst so entries never interleave, followed
//               by one turnaround cycle before the next arbitration.
//               Optional grant-hold watchdog: define SPAWNOUT_ARB_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module spawnout_queue_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_BITS  = 32,
  parameter int DATA_BITS  = 64,
  parameter int WDT_CYCLES = 1024
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  spawnout_queue_arbiter_if.slave   arb_if
);

  localparam int BE_BITS = DATA_BITS / 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  localparam logic [2:0]         RR_RESET = 3'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  generate
    if (NUM_REQ < 2 || NUM_REQ > 8 || WDT_CYCLES < 1 || WDT_CYCLES > 65535) begin : g_bad_cfg
      $error("spawnout_queue_arbiter: unsupported parameter set");
    end
  endgenerate

  logic [1:0]         state_q,  state_d;
  logic [NUM_REQ-1:0] gnt_q,    gnt_d;
  logic [2:0]         owner_q,  owner_d;
  logic               busy_q,   busy_d;
  logic [2:0]         rr_ptr_q, rr_ptr_d;

`ifdef SPAWNOUT_ARB_WATCHDOG_EN
  localparam logic [15:0] WDT_LAST = 16'(WDT_CYCLES - 1);
  logic [15:0]        wdt_cnt_q, wdt_cnt_d;
  logic               wdt_err_q, wdt_err_d;
`endif

  // arbitration result
  logic               win_found;
  logic [2:0]         win_idx;
  int                 cand;

  // current owner's signals
  logic                 own_req;
  logic                 own_done;
  logic                 own_en;
  logic [BE_BITS-1:0]   own_we;
  logic [ADDR_BITS-1:0] own_addr;
  logic [DATA_BITS-1:0] own_din;

  // Round-robin search: first requester after the last winner, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!win_found && arb_if.req[cand]) begin
        win_found = 1'b1;
        win_idx   = 3'(cand);
      end
    end
  end

  // Select the registered owner's request, done and port slice.
  always_comb begin
    own_req  = 1'b0;
    own_done = 1'b0;
    own_en   = 1'b0;
    own_we   = '0;
    own_addr = '0;
    own_din  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == 3'(i)) begin
        own_req  = arb_if.req[i];
        own_done = arb_if.done[i];
        own_en   = arb_if.req_en[i];
        own_we   = arb_if.req_we[i*BE_BITS +: BE_BITS];
        own_addr = arb_if.req_addr[i*ADDR_BITS +: ADDR_BITS];
        own_din  = arb_if.req_din[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  // State register: all arbiter flops, synchronous reset drops any grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      owner_q   <= 3'd0;
      busy_q    <= 1'b0;
      rr_ptr_q  <= RR_RESET;
`ifdef SPAWNOUT_ARB_WATCHDOG_EN
      wdt_cnt_q <= 16'd0;
      wdt_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
      rr_ptr_q  <= rr_ptr_d;
`ifdef SPAWNOUT_ARB_WATCHDOG_EN
      wdt_cnt_q <= wdt_cnt_d;
      wdt_err_q <= wdt_err_d;
`endif
    end
  end

  // Next-state logic: grant on arbitration, release on done/abandon/timeout.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    busy_d    = busy_q;
    rr_ptr_d  = rr_ptr_q;
`ifdef SPAWNOUT_ARB_WATCHDOG_EN
    wdt_cnt_d = wdt_cnt_q;
    wdt_err_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d   = ST_GRANT;
          gnt_d     = ONE_HOT0 << win_idx;
          owner_d   = win_idx;
          busy_d    = 1'b1;
          rr_ptr_d  = win_idx;
`ifdef SPAWNOUT_ARB_WATCHDOG_EN
          wdt_cnt_d = 16'd0;
`endif
        end
      end
      ST_GRANT: begin
`ifdef SPAWNOUT_ARB_WATCHDOG_EN
        wdt_cnt_d = wdt_cnt_q + 16'd1;
`endif
        // done or abandon wins over a coincident timeout
        if (own_done || !own_req) begin
          state_d = ST_RELEASE;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end
`ifdef SPAWNOUT_ARB_WATCHDOG_EN
        else if (wdt_cnt_q == WDT_LAST) begin
          state_d   = ST_RELEASE;
          gnt_d     = '0;
          busy_d    = 1'b0;
          wdt_err_d = 1'b1;
        end
`endif
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Output logic: only the registered owner reaches the memory, and only in GRANT.
  always_comb begin
    arb_if.spawnout_queue_en   = 1'b0;
    arb_if.spawnout_queue_we   = '0;
    arb_if.spawnout_queue_addr = '0;
    arb_if.spawnout_queue_din  = '0;
    if (state_q == ST_GRANT) begin
      arb_if.spawnout_queue_en   = own_en;
      arb_if.spawnout_queue_we   = own_we;
      arb_if.spawnout_queue_addr = own_addr;
      arb_if.spawnout_queue_din  = own_din;
    end
  end

  assign arb_if.gnt      = gnt_q;
  assign arb_if.owner    = owner_q;
  assign arb_if.busy     = busy_q;
  assign arb_if.req_dout = {NUM_REQ{arb_if.spawnout_queue_dout}};

`ifdef SPAWNOUT_ARB_WATCHDOG_EN
  assign arb_if.wdt_err = wdt_err_q;
`else
  assign arb_if.wdt_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spawnout_queue_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spawnout_queue_arbiter
// Description : Self-checking bench for spawnout_queue_arbiter against a
//               cycle-level behavioural model of the arbitration rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spawnout_queue_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int ADDR_BITS  = 32;
  localparam int DATA_BITS  = 64;
  localparam int WDT_CYCLES = 16;
  localparam int BE_BITS    = DATA_BITS / 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spawnout_queue_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS)) bus ();

  spawnout_queue_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS), .WDT_CYCLES(WDT_CYCLES)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .arb_if (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: who holds the port, turnaround pending, last winner
  int   m_holder = -1;
  int   m_dead   = 0;
  int   m_last   = NUM_REQ - 1;
  int   m_cnt    = 0;
  bit   m_wdt    = 1'b0;
  bit   m_known  = 1'b0;

  logic [NUM_REQ-1:0] prev_gnt = '0;
  int   grant_log[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit rel;
    if (rst) begin
      m_holder = -1; m_dead = 0; m_last = NUM_REQ - 1; m_cnt = 0; m_wdt = 1'b0;
      m_known  = 1'b1;
    end else begin
      m_wdt = 1'b0;
      if (m_holder >= 0) begin
        rel = bus.done[m_holder] || !bus.req[m_holder];
        m_cnt++;
`ifdef SPAWNOUT_ARB_WATCHDOG_EN
        if (!rel && m_cnt >= WDT_CYCLES) begin
          rel   = 1'b1;
          m_wdt = 1'b1;
        end
`endif
        if (rel) begin
          m_holder = -1;
          m_dead   = 1;
        end
      end else if (m_dead > 0) begin
        m_dead = 0;
      end else if (bus.req != '0) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          if (bus.req[(m_last + k) % NUM_REQ]) begin
            m_holder = (m_last + k) % NUM_REQ;
            break;
          end
        end
        m_last = m_holder;
        m_cnt  = 0;
      end
    end
  endtask

  task automatic check_comb();
    logic [ADDR_BITS-1:0] ea;
    logic [BE_BITS-1:0]   ew;
    logic [DATA_BITS-1:0] ed;
    logic                 ee;
    ea = '0; ew = '0; ed = '0; ee = 1'b0;
    if (m_holder >= 0) begin
      ee = bus.req_en[m_holder];
      ew = bus.req_we[m_holder*BE_BITS +: BE_BITS];
      ea = bus.req_addr[m_holder*ADDR_BITS +: ADDR_BITS];
      ed = bus.req_din[m_holder*DATA_BITS +: DATA_BITS];
    end
    check_eq("port_en",   64'(bus.spawnout_queue_en),   64'(ee));
    check_eq("port_we",   64'(bus.spawnout_queue_we),   64'(ew));
    check_eq("port_addr", 64'(bus.spawnout_queue_addr), 64'(ea));
    check_eq("port_din",  64'(bus.spawnout_queue_din),  64'(ed));
    for (int i = 0; i < NUM_REQ; i++)
      check_eq("dout_fanout", 64'(bus.req_dout[i*DATA_BITS +: DATA_BITS]), 64'(bus.spawnout_queue_dout));
  endtask

  task automatic check_regs();
    logic [NUM_REQ-1:0] eg;
    eg = '0;
    if (m_holder >= 0) eg[m_holder] = 1'b1;
    check_eq("gnt",     64'(bus.gnt),     64'(eg));
    check_eq("busy",    64'(bus.busy),    64'(m_holder >= 0));
    check_eq("wdt_err", 64'(bus.wdt_err), 64'(m_wdt));
    if (m_holder >= 0) check_eq("owner", 64'(bus.owner), 64'(m_holder));
  endtask

  // one clock: combinational port check, edge, model update, registered check
  task automatic cycle();
    #2;
    if (m_known) check_comb();
    @(posedge clk);
    model_edge();
    #1;
    check_regs();
    if (prev_gnt == '0 && bus.gnt != '0) grant_log.push_back(int'(bus.owner));
    prev_gnt = bus.gnt;
  endtask

  task automatic idle_inputs();
    bus.req = '0; bus.done = '0; bus.req_en = '0; bus.req_we = '0;
    bus.req_addr = '0; bus.req_din = '0; bus.spawnout_queue_dout = '0;
  endtask

  task automatic random_data();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_addr[i*ADDR_BITS +: ADDR_BITS] = $urandom;
      bus.req_din[i*DATA_BITS +: DATA_BITS]  = {$urandom, $urandom};
      bus.req_we[i*BE_BITS +: BE_BITS]       = BE_BITS'($urandom);
      bus.req_en[i]                          = $urandom_range(0, 1) == 1;
    end
    bus.spawnout_queue_dout = {$urandom, $urandom};
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) cycle();
    rst = 1'b0;
  endtask

  task automatic write_slot(input int r, input logic [31:0] a, input logic [63:0] d);
    bus.req_en[r] = 1'b1;
    bus.req_we[r*BE_BITS +: BE_BITS] = '1;
    bus.req_addr[r*ADDR_BITS +: ADDR_BITS] = a;
    bus.req_din[r*DATA_BITS +: DATA_BITS] = d;
  endtask

  initial begin
    int exp_order[5];
    exp_order = '{0, 1, 3, 0, 1};
    rst = 1'b1;
    idle_inputs();

    // 1: reset with all requesting, then requester 0 first
    bus.req = 4'b1111;
    do_reset(3);
    check_eq("t1_rst_gnt",   64'(bus.gnt),   64'd0);
    check_eq("t1_rst_owner", 64'(bus.owner), 64'd0);
    check_eq("t1_rst_busy",  64'(bus.busy),  64'd0);
    cycle();
    check_eq("t1_first_gnt", 64'(bus.gnt), 64'b0001);

    // 2: single burst by requester 2
    idle_inputs();
    do_reset(2);
    bus.req = 4'b0100;
    cycle();
    check_eq("t2_owner", 64'(bus.owner), 64'd2);
    write_slot(2, 32'd8,  64'h0000_0000_0000_1111); cycle();
    write_slot(2, 32'd16, 64'h0000_0000_0000_2222); cycle();
    write_slot(2, 32'd24, 64'h0000_0000_0000_3333); cycle();
    write_slot(2, 32'd0,  64'h8000_0000_0000_0044);
    bus.done[2] = 1'b1;
    #2;
    check_eq("t2_hdr_addr", 64'(bus.spawnout_queue_addr), 64'd0);
    check_eq("t2_hdr_din",  64'(bus.spawnout_queue_din),  64'h8000_0000_0000_0044);
    cycle();
    check_eq("t2_gnt_rel", 64'(bus.gnt), 64'd0);
    idle_inputs();
    bus.req_en[2] = 1'b1;
    #2;
    check_eq("t2_en_rel", 64'(bus.spawnout_queue_en), 64'd0);
    cycle();

    // 3: round robin with 1-access bursts
    idle_inputs();
    do_reset(2);
    grant_log.delete();
    bus.req = 4'b1011;
    for (int c = 0; c < 16; c++) begin
      bus.done = '0; bus.req_en = '0;
      if (m_holder >= 0) begin
        bus.done[m_holder]   = 1'b1;
        bus.req_en[m_holder] = 1'b1;
      end
      cycle();
    end
    check_eq("t3_n_grants", 64'(grant_log.size() >= 5), 64'd1);
    for (int i = 0; i < 5; i++)
      if (i < grant_log.size()) check_eq("t3_order", 64'(grant_log[i]), 64'(exp_order[i]));

    // 4: isolation from a non-owner
    idle_inputs();
    do_reset(2);
    bus.req = 4'b0010;
    cycle();
    bus.req = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      write_slot(1, 32'(8 * c + 64), 64'(c + 100));
      write_slot(3, 32'd0, 64'hDEAD_BEEF_DEAD_BEEF);
      bus.req_en[1] = (c != 2);
      bus.done[3]   = (c == 1);
      cycle();
    end
    check_eq("t4_gnt_keep", 64'(bus.gnt), 64'b0010);
    bus.done = 4'b0010;
    cycle();
    bus.done = '0;
    cycle();
    cycle();
    check_eq("t4_next_gnt", 64'(bus.gnt), 64'b1000);

    // 5: abandon, then reset mid-grant
    idle_inputs();
    do_reset(2);
    bus.req = 4'b0001;
    cycle();
    write_slot(0, 32'd8, 64'd1);
    cycle();
    bus.req = '0;
    cycle();
    check_eq("t5_abandon", 64'(bus.gnt), 64'd0);
    cycle(); cycle();
    bus.req = 4'b0010;
    cycle();
    write_slot(1, 32'd16, 64'd2);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    bus.req = '0;
    check_eq("t5_rst_gnt", 64'(bus.gnt), 64'd0);
    #2;
    check_eq("t5_rst_en", 64'(bus.spawnout_queue_en), 64'd0);
    cycle();

    // 6: owner never signals done
    idle_inputs();
    do_reset(2);
    bus.req = 4'b0011;
    for (int c = 0; c < 120; c++) begin
      bus.req_en[0] = 1'b1;
      cycle();
    end
`ifndef SPAWNOUT_ARB_WATCHDOG_EN
    check_eq("t6_held", 64'(bus.gnt), 64'b0001);
`endif

    // randomized traffic against the model
    idle_inputs();
    do_reset(2);
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (m_holder == i) bus.req[i] = ($urandom_range(0, 15) != 0);
        else if ($urandom_range(0, 3) == 0) bus.req[i] = ~bus.req[i];
        bus.done[i] = ($urandom_range(0, 5) == 0);
      end
      random_data();
      cycle();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
